// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit holding the HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [4:0]  cnt;
  logic        is_div, neg, sa, bz;
  logic [31:0] mb, a_q, r, diff, ma, mbb, qn, rn;
  logic [63:0] p, pn;
  logic [32:0] sum, shifted;
  logic        sgn, go, ge;
  assign sgn  = ~op[0];
  assign go   = start && state == IDLE;
  assign ma   = sgn && A[31] ? -A : A;
  assign mbb  = sgn && B[31] ? -B : B;
  assign busy = state != IDLE;
  // multiply step: conditionally add multiplicand to the upper half before shifting right
  assign sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, mb} : 33'd0);
  // divide step: bring in the next dividend bit and try subtracting the divisor
  assign shifted = {r, p[31]};
  assign ge      = shifted >= {1'b0, mb};
  assign diff    = shifted[31:0] - mb;
  assign pn = neg ? -p : p;
  assign qn = neg ? -p[31:0] : p[31:0];
  assign rn = sa ? -r : r;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: only multi-cycle ops leave IDLE; RUN lasts 32 cycles, FIX one
  always_comb begin
    state_n = state;
    if (go && !op[2]) state_n = RUN;
    else if (state == RUN && cnt == 5'd31) state_n = FIX;
    else if (state == FIX) state_n = IDLE;
  end
  // datapath: operand latch, iteration, sign fix-up and HI/LO writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; is_div <= 1'b0; neg <= 1'b0; sa <= 1'b0; bz <= 1'b0;
      mb <= '0; a_q <= '0; r <= '0; p <= '0; hi <= '0; lo <= '0; done <= 1'b0;
    end else begin
      done <= state == FIX;
      if (go && op == 3'd4) hi <= A;
      if (go && op == 3'd5) lo <= A;
      if (go && !op[2]) begin
        cnt    <= '0;
        is_div <= op[1];
        neg    <= sgn && (A[31] ^ B[31]);
        sa     <= sgn && op[1] && A[31];
        bz     <= B == 32'd0;
        a_q    <= A;
        r      <= '0;
        mb     <= op[1] ? mbb : ma;
        p      <= {32'd0, op[1] ? ma : mbb};
      end
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (is_div) begin
          r       <= ge ? diff : shifted[31:0];
          p[31:0] <= {p[30:0], ge};
        end else p <= {sum, p[31:1]};
      end
      if (state == FIX) begin
        hi <= !is_div ? pn[63:32] : bz ? a_q : rn;
        lo <= !is_div ? pn[31:0] : bz ? 32'hFFFFFFFF : qn;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
                   .busy(busy), .done(done), .hi(hi), .lo(lo));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] sq, sr;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 3'd0) return sx * sy;
    if (o == 3'd1) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 3'd3) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    sq = $signed(x) / $signed(y);
    sr = $signed(x) % $signed(y);
    return {sr, sq};
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    int n, bc;
    logic [63:0] prev, e;
    n = 0;
    bc = 0;
    prev = {hi, lo};
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (n == 16) check("hold", {hi, lo}, prev);
      if (n == poke) begin
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("latency", n, 33);
    check("busy_cycles", bc, 33);
    check("result", {hi, lo}, e);
    check("busy_low", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, -1);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, -1);
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -1);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    run_op(3'd3, 32'h64, 32'd0, -1);
    check("divu_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
    run_op(3'd2, 32'hFFFFFF9C, 32'd0, -1);
    check("div_zero_neg", {hi, lo}, 64'hFFFFFF9C_FFFFFFFF);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'hFFFFFFFF);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    run_op(3'd3, 32'd10, 32'd3, 5);
    check("divu_ignored", {hi, lo}, 64'h00000001_00000003);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hCAFEF00D; b = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("arst_no_done", seen, 0);
    check("arst_idle", busy, 0);
    for (int i = 0; i < 6; i++)
      run_op(3'($urandom_range(0, 3)), $urandom, $urandom, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
